// File: rtl/axi_traffic_gen_if.sv
// axi_traffic_gen_if: AXI4 signal bundle between the traffic generator (master) and a slave
// Channels: AW/AR address+id+len+size+burst, W data/strb/last, B id response, R id/data/last.
interface axi_traffic_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 16
);
  logic awvalid, awready;
  logic [ID_WIDTH-1:0] awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic wvalid, wready, wstrb, wlast;
  logic [DATA_WIDTH-1:0] wdata;
  logic bvalid, bready;
  logic [ID_WIDTH-1:0] bid;
  logic arvalid, arready;
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic rvalid, rready, rlast;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bid, arready, rvalid, rid, rdata, rlast
  );
  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bid, arready, rvalid, rid, rdata, rlast
  );
endinterface

// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: issues txn_count INCR bursts (write or read) at base_addr + idx*addr_stride
// Inputs: aclk, aresetn (async, active-low), start pulse with rw/txn_count/burst_len/base_addr/addr_stride.
// Outputs: busy, done pulse, err_count (id/last mismatches), cycle_count (busy cycles); m = AXI master.
module axi_traffic_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 16
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic start,
  input  logic rw,
  input  logic [15:0] txn_count,
  input  logic [7:0] burst_len,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] addr_stride,
  output logic busy,
  output logic done,
  output logic [15:0] err_count,
  output logic [31:0] cycle_count,
  axi_traffic_gen_if.master m
);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FIN} state_t;
  state_t state_q;
  logic rw_q, awvalid_q, arvalid_q, wvalid_q, wlast_q, bready_q, rready_q, done_q;
  logic [15:0] cnt_q, idx_q, err_q;
  logic [7:0] len_q, beat_q;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [31:0] cyc_q;
  logic [15:0] idx_d;
  logic [7:0] beat_d;
  logic more_d, fin_hs_d, err_d;
  always_comb begin
    idx_d = idx_q + 16'd1;
    beat_d = beat_q + 8'd1;
    more_d = idx_d < cnt_q;
    // completion of a transaction: B handshake, or the final R beat regardless of RLAST
    fin_hs_d = (bready_q && m.bvalid) || (rready_q && m.rvalid && beat_q == len_q);
    err_d = (bready_q && m.bvalid && m.bid != id_q) ||
            (rready_q && m.rvalid && (m.rid != id_q || m.rlast != (beat_q == len_q)));
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      {rw_q, awvalid_q, arvalid_q, wvalid_q, wlast_q, bready_q, rready_q, done_q} <= '0;
      {cnt_q, idx_q, err_q, len_q, beat_q, cyc_q} <= '0;
      addr_q <= '0;
      stride_q <= '0;
      id_q <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
      if (err_d && err_q != '1) err_q <= err_q + 16'd1;
      case (state_q)
        IDLE: if (start) begin
          rw_q <= rw;
          cnt_q <= txn_count;
          len_q <= burst_len;
          addr_q <= base_addr;
          stride_q <= addr_stride;
          idx_q <= '0;
          id_q <= '0;
          err_q <= '0;
          cyc_q <= '0;
          awvalid_q <= !rw && txn_count != 16'd0;
          arvalid_q <= rw && txn_count != 16'd0;
          done_q <= txn_count == 16'd0;
          state_q <= txn_count == 16'd0 ? FIN : rw ? AR : AW;
        end
        AW: if (m.awready) begin
          awvalid_q <= 1'b0;
          wvalid_q <= 1'b1;
          wdata_q <= DATA_WIDTH'(addr_q[7:0]);
          wlast_q <= len_q == 8'd0;
          beat_q <= '0;
          state_q <= W;
        end
        W: if (m.wready) begin
          if (wlast_q) begin
            wvalid_q <= 1'b0;
            wlast_q <= 1'b0;
            bready_q <= 1'b1;
            state_q <= B;
          end else begin
            beat_q <= beat_d;
            wdata_q <= DATA_WIDTH'(addr_q[7:0] + beat_d);
            wlast_q <= beat_d == len_q;
          end
        end
        AR: if (m.arready) begin
          arvalid_q <= 1'b0;
          rready_q <= 1'b1;
          beat_q <= '0;
          state_q <= R;
        end
        R: if (m.rvalid && beat_q != len_q) beat_q <= beat_d;
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (fin_hs_d) begin
        bready_q <= 1'b0;
        rready_q <= 1'b0;
        idx_q <= idx_d;
        if (more_d) begin
          // stepping by stride is idx*stride with natural wrap at ADDR_WIDTH
          addr_q <= addr_q + stride_q;
          id_q <= idx_d[ID_WIDTH-1:0];
          awvalid_q <= !rw_q;
          arvalid_q <= rw_q;
          state_q <= rw_q ? AR : AW;
        end else begin
          done_q <= 1'b1;
          state_q <= FIN;
        end
      end
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err_count = err_q;
  assign cycle_count = cyc_q;
  assign m.awvalid = awvalid_q;
  assign m.awid = id_q;
  assign m.awaddr = addr_q;
  assign m.awlen = len_q;
  assign m.awsize = 3'd0;
  assign m.awburst = 2'b01;
  assign m.wvalid = wvalid_q;
  assign m.wdata = wdata_q;
  assign m.wstrb = wvalid_q;
  assign m.wlast = wlast_q;
  assign m.bready = bready_q;
  assign m.arvalid = arvalid_q;
  assign m.arid = id_q;
  assign m.araddr = addr_q;
  assign m.arlen = len_q;
  assign m.arsize = 3'd0;
  assign m.arburst = 2'b01;
  assign m.rready = rready_q;
endmodule
